// File: rtl/regfile_mp.sv
// Multi-port register file with a busy scoreboard for the MIPS datapath.
// It has two write ports (port 1 wins on a same-address collision), NRD
// combinational read ports and a per-register busy bit that decode uses to
// detect RAW hazards. pend_cnt is a registered count of the busy registers.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   we0/wa0/wd0       write port 0
//   we1/wa1/wd1       write port 1 (priority port)
//   ra / rd / rbusy   packed read addresses, read data and busy bits, NRD ports
//   busy_set/busy_sa  mark a register pending (its producer has issued)
//   pend_cnt          number of busy registers, 0..DEPTH
//
// Optional feature: define RF_BYPASS_EN for write-through forwarding. A
// same-cycle write then appears on rd and clears rbusy. Without the macro,
// rd and rbusy show stored state only.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  busy_set,
  input  logic [ADDR_W-1:0]     busy_sa,
  output logic [ADDR_W:0]       pend_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

  // Register 0 is hard-wired when ZeroEn, so writes and busy_set to it are dropped.
  logic we0_eff, we1_eff, set_eff;
  assign we0_eff = we0 & ~(ZeroEn && (wa0 == '0));
  assign we1_eff = we1 & ~(ZeroEn && (wa1 == '0));
  assign set_eff = busy_set & ~(ZeroEn && (busy_sa == '0));

  // Port 1 is applied last so it overrides port 0 on an address collision.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
    end
    if (we0_eff) mem_d[wa0] = wd0;
    if (we1_eff) mem_d[wa1] = wd1;
  end

  // A new producer (set) wins over a retiring write (clear) to the same register.
  always_comb begin
    busy_d     = '0;
    pend_cnt_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      busy_d[r] = (set_eff & (busy_sa == ADDR_W'(r))) |
                  (busy_q[r] & ~(we0 & (wa0 == ADDR_W'(r))) & ~(we1 & (wa1 == ADDR_W'(r))));
      pend_cnt_d = pend_cnt_d + (ADDR_W + 1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [ADDR_W-1:0] addr;
      addr = ra[i*ADDR_W +: ADDR_W];
      if (ZeroEn && (addr == '0)) begin
        rd[i*DATA_W +: DATA_W] = '0;
        rbusy[i]               = 1'b0;
      end else begin
        rd[i*DATA_W +: DATA_W] = mem_q[addr];
        rbusy[i]               = busy_q[addr];
`ifdef RF_BYPASS_EN
        if (we1_eff && (wa1 == addr)) begin
          rd[i*DATA_W +: DATA_W] = wd1;
          rbusy[i]               = busy_set & (busy_sa == addr);
        end else if (we0_eff && (wa0 == addr)) begin
          rd[i*DATA_W +: DATA_W] = wd0;
          rbusy[i]               = busy_set & (busy_sa == addr);
        end
`endif
      end
    end
  end

endmodule
